// File: rtl/vc_input_port.sv
// Multi-VC router input port: one flit FIFO and route-reservation FSM per VC,
// with a round-robin arbiter that forwards flits of granted VCs.
//
// state     | meaning
// S_IDLE    | no route held; waiting for a head flit at the FIFO front
// S_REQUEST | route requested from the front head flit; waiting for grant
// S_ACTIVE  | route held; flits forwarded until the tail is popped
module vc_input_port #(
    parameter int VC            = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int TYPE_WIDTH    = 2,
    parameter int REQUEST_WIDTH = 2,
    parameter int FIFO_DEPTH    = 8,
    localparam int VCW          = $clog2(VC)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic [VCW-1:0]              in_vc,
    input  logic                        in_valid,
    output logic [VC-1:0]               in_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic [VCW-1:0]              out_vc,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [VC-1:0]               route_req_valid,
    output logic [VC*REQUEST_WIDTH-1:0] route_req,
    input  logic [VC-1:0]               route_grant,
    output logic [VC-1:0]               route_relieve,
    output logic                        proto_err
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_REQUEST, S_ACTIVE} state_t;

    state_t                state      [VC];
    state_t                state_next [VC];
    logic [DATA_WIDTH-1:0] mem        [VC][FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr     [VC];
    logic [PW-1:0]         wr_ptr     [VC];
    logic [CW-1:0]         count      [VC];
    logic [DATA_WIDTH-1:0] front      [VC];
    logic [1:0]            ftype      [VC];

    logic [VC-1:0]  push, pop, empty, full, is_head, is_tail;
    logic [VC-1:0]  eligible, stray, relieve_next, relieve_q;
    logic [VCW-1:0] rr, sel;
    logic           any_eligible, handshake, proto_err_q;
    int             arb_idx;

    for (genvar v = 0; v < VC; v++) begin : g_vc
        assign front[v]    = mem[v][rd_ptr[v]];
        assign ftype[v]    = front[v][DATA_WIDTH-TYPE_WIDTH +: 2];
        assign empty[v]    = (count[v] == '0);
        assign full[v]     = (count[v] == CW'(FIFO_DEPTH));
        assign is_head[v]  = ~ftype[v][1];
        assign is_tail[v]  = (ftype[v] == 2'b00) || (ftype[v] == 2'b11);
        assign eligible[v] = (state[v] == S_ACTIVE) && !empty[v];
        assign stray[v]    = (state[v] == S_IDLE) && !empty[v] && !is_head[v];
        assign push[v]     = in_valid && (in_vc == VCW'(v)) && !full[v];
        assign pop[v]      = stray[v] || (handshake && (sel == VCW'(v)));
        assign route_req_valid[v] = (state[v] == S_REQUEST);
        assign route_req[v*REQUEST_WIDTH +: REQUEST_WIDTH] =
            (state[v] == S_REQUEST) ? front[v][REQUEST_WIDTH-1:0] : '0;
    end

    // Round-robin: first eligible VC at or after rr, wrapping modulo VC.
    always_comb begin
        sel          = '0;
        any_eligible = 1'b0;
        arb_idx      = 0;
        for (int i = 0; i < VC; i++) begin
            arb_idx = int'(rr) + i;
            if (arb_idx >= VC) arb_idx = arb_idx - VC;
            if (!any_eligible && eligible[arb_idx]) begin
                sel          = VCW'(arb_idx);
                any_eligible = 1'b1;
            end
        end
    end

    assign handshake = any_eligible && out_ready;
    assign out_valid = any_eligible;
    assign out_vc    = sel;
    assign out_data  = front[sel];
    assign in_ready  = ~full;

    always_comb begin
        for (int v = 0; v < VC; v++) begin
            state_next[v]   = state[v];
            relieve_next[v] = 1'b0;
            case (state[v])
                S_IDLE:    if (!empty[v] && is_head[v]) state_next[v] = S_REQUEST;
                S_REQUEST: if (route_grant[v]) state_next[v] = S_ACTIVE;
                S_ACTIVE: begin
                    if (pop[v] && is_tail[v]) begin
                        state_next[v]   = S_IDLE;
                        relieve_next[v] = 1'b1;
                    end
                end
                default:   state_next[v] = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int v = 0; v < VC; v++) begin
            if (rst) state[v] <= S_IDLE;
            else     state[v] <= state_next[v];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < VC; v++) begin
                rd_ptr[v] <= '0;
                wr_ptr[v] <= '0;
                count[v]  <= '0;
            end
        end else begin
            for (int v = 0; v < VC; v++) begin
                if (push[v]) wr_ptr[v] <= wr_ptr[v] + 1'b1;
                if (pop[v])  rd_ptr[v] <= rd_ptr[v] + 1'b1;
                if (push[v] && !pop[v])      count[v] <= count[v] + 1'b1;
                else if (!push[v] && pop[v]) count[v] <= count[v] - 1'b1;
            end
        end
    end

    // Flit storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        for (int v = 0; v < VC; v++) begin
            if (push[v]) mem[v][wr_ptr[v]] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr          <= '0;
            relieve_q   <= '0;
            proto_err_q <= 1'b0;
        end else begin
            if (handshake) rr <= (sel == VCW'(VC-1)) ? '0 : sel + 1'b1;
            relieve_q   <= relieve_next;
            proto_err_q <= |stray;
        end
    end

    assign route_relieve = relieve_q;
    assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_vc_input_port.sv
// Directed bench for vc_input_port: scoreboard of expected output flits plus
// cycle-exact checks of route request, relieve, proto_err and in_ready.
module tb_vc_input_port;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic [1:0]  in_vc;
    logic        in_valid;
    logic [3:0]  in_ready;
    logic [31:0] out_data;
    logic [1:0]  out_vc;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  route_req_valid;
    logic [7:0]  route_req;
    logic [3:0]  route_grant;
    logic [3:0]  route_relieve;
    logic        proto_err;

    int total = 0;
    int bad   = 0;
    logic [33:0] exp_q [$];

    vc_input_port dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_vc(in_vc), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_vc(out_vc), .out_valid(out_valid), .out_ready(out_ready),
        .route_req_valid(route_req_valid), .route_req(route_req),
        .route_grant(route_grant), .route_relieve(route_relieve), .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [1:0] t, input logic [27:0] p,
                                       input logic [1:0] r);
        return {t, p, r};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Settle, score any handshake of the current cycle, then advance one clock.
    task automatic tick();
        #1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("sb_unexpected_pop", 64'(exp_q.size()), 64'd1);
            else chk("sb_flit", 64'({out_vc, out_data}), 64'(exp_q.pop_front()));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int v, input logic [31:0] d, input bit expect_out);
        in_valid = 1'b1;
        in_vc    = 2'(v);
        in_data  = d;
        if (expect_out) exp_q.push_back({2'(v), d});
    endtask

    task automatic wait_relieve(input int v, input string tag);
        int n = 0;
        while (!route_relieve[v] && n < 60) begin tick(); n++; end
        chk(tag, 64'(n < 60), 64'd1);
    endtask

    task automatic send_pkt(input int v, input int n, input logic [1:0] r,
                            input logic [27:0] base);
        logic [1:0] t;
        int w = 0;
        for (int i = 0; i < n; i++) begin
            t = (n == 1) ? 2'b00 : (i == 0) ? 2'b01 : (i == n - 1) ? 2'b11 : 2'b10;
            drive(v, mk(t, base + 28'(i), r), 1'b1);
            tick();
        end
        in_valid = 1'b0;
        while (!route_req_valid[v] && w < 20) begin tick(); w++; end
        chk("pkt_req_seen", 64'(w < 20), 64'd1);
        chk("pkt_req_route", 64'(route_req[v*2 +: 2]), 64'(r));
        route_grant[v] = 1'b1;
        tick();
        route_grant = '0;
        wait_relieve(v, "pkt_relieve_seen");
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_vc = '0; in_valid = 1'b0;
        out_ready = 1'b0; route_grant = '0;
        tick(); tick();
        chk("rst_in_ready", 64'(in_ready), 64'hf);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_req_valid", 64'(route_req_valid), 64'd0);
        chk("rst_relieve", 64'(route_relieve), 64'd0);
        chk("rst_proto_err", 64'(proto_err), 64'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();

        // Interleave: VC0 and VC2 granted together, rr starts at 0.
        drive(0, mk(2'b01, 28'h0a0, 2'b00), 1'b0); exp_q.push_back({2'd0, mk(2'b01, 28'h0a0, 2'b00)}); tick();
        drive(0, mk(2'b10, 28'h0a1, 2'b00), 1'b0); tick();
        drive(0, mk(2'b11, 28'h0a2, 2'b00), 1'b0); tick();
        drive(2, mk(2'b01, 28'h2a0, 2'b01), 1'b0); exp_q.push_back({2'd2, mk(2'b01, 28'h2a0, 2'b01)}); tick();
        exp_q.push_back({2'd0, mk(2'b10, 28'h0a1, 2'b00)});
        drive(2, mk(2'b10, 28'h2a1, 2'b01), 1'b0); exp_q.push_back({2'd2, mk(2'b10, 28'h2a1, 2'b01)}); tick();
        exp_q.push_back({2'd0, mk(2'b11, 28'h0a2, 2'b00)});
        drive(2, mk(2'b11, 28'h2a2, 2'b01), 1'b0); exp_q.push_back({2'd2, mk(2'b11, 28'h2a2, 2'b01)}); tick();
        in_valid = 1'b0;
        chk("il_req_valid", 64'(route_req_valid), 64'h5);
        chk("il_req_route0", 64'(route_req[1:0]), 64'd0);
        chk("il_req_route2", 64'(route_req[5:4]), 64'd1);
        route_grant = 4'b0101;
        tick();
        route_grant = '0;
        chk("il_first_vc", 64'(out_vc), 64'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("il_relieve0", 64'(route_relieve), 64'h1);
        tick();
        chk("il_relieve2", 64'(route_relieve), 64'h4);

        // Stall: out_ready low for 3 cycles mid-packet on VC1.
        drive(1, mk(2'b01, 28'h1b0, 2'b11), 1'b1); tick();
        drive(1, mk(2'b10, 28'h1b1, 2'b11), 1'b1); tick();
        drive(1, mk(2'b10, 28'h1b2, 2'b11), 1'b1); tick();
        drive(1, mk(2'b11, 28'h1b3, 2'b11), 1'b1); tick();
        in_valid = 1'b0;
        route_grant = 4'b0010;
        tick();
        route_grant = '0;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_data", 64'(out_data), 64'(mk(2'b10, 28'h1b1, 2'b11)));
            chk("stall_vc", 64'(out_vc), 64'd1);
            tick();
        end
        chk("stall_data_end", 64'(out_data), 64'(mk(2'b10, 28'h1b1, 2'b11)));
        out_ready = 1'b1;
        wait_relieve(1, "stall_relieve_seen");
        tick();

        // Cycle-exact 4-flit packet on VC1, head route 2'b10.
        drive(1, mk(2'b01, 28'h100, 2'b10), 1'b1); tick();
        chk("t1_c1_req", 64'(route_req_valid), 64'd0);
        drive(1, mk(2'b10, 28'h101, 2'b10), 1'b1); tick();
        chk("t1_c2_req", 64'(route_req_valid), 64'h2);
        chk("t1_c2_route", 64'(route_req[3:2]), 64'h2);
        chk("t1_c2_out_valid", 64'(out_valid), 64'd0);
        route_grant = 4'b0010;
        drive(1, mk(2'b10, 28'h102, 2'b10), 1'b1); tick();
        route_grant = '0;
        chk("t1_c3_out_valid", 64'(out_valid), 64'd1);
        chk("t1_c3_out_vc", 64'(out_vc), 64'd1);
        chk("t1_c3_req", 64'(route_req_valid), 64'd0);
        drive(1, mk(2'b11, 28'h103, 2'b10), 1'b1); tick();
        in_valid = 1'b0;
        tick(); tick();
        chk("t1_c6_relieve", 64'(route_relieve), 64'd0);
        chk("t1_c6_out_valid", 64'(out_valid), 64'd1);
        tick();
        chk("t1_c7_relieve", 64'(route_relieve), 64'h2);
        chk("t1_c7_out_valid", 64'(out_valid), 64'd0);
        tick();
        chk("t1_c8_relieve", 64'(route_relieve), 64'd0);

        // Fill VC0 while ungranted, then drain and wrap pointers.
        for (int i = 0; i < 8; i++) begin
            drive(0, mk((i == 0) ? 2'b01 : (i == 7) ? 2'b11 : 2'b10, 28'h300 + 28'(i), 2'b01), 1'b1);
            tick();
        end
        chk("fill_in_ready", 64'(in_ready), 64'he);
        drive(0, mk(2'b10, 28'hbad, 2'b01), 1'b0);
        tick();
        in_valid = 1'b0;
        chk("fill_full_hold", 64'(in_ready), 64'he);
        chk("fill_req", 64'(route_req_valid), 64'h1);
        route_grant = 4'b0001;
        tick();
        route_grant = '0;
        chk("fill_active_valid", 64'(out_valid), 64'd1);
        chk("fill_before_pop", 64'(in_ready), 64'he);
        tick();
        chk("fill_after_pop", 64'(in_ready), 64'hf);
        wait_relieve(0, "fill_relieve_seen");
        tick();
        send_pkt(0, 5, 2'b10, 28'h400);
        tick();
        send_pkt(0, 5, 2'b11, 28'h500);
        tick();

        // Stray body on idle VC3, then a head-tail packet.
        drive(3, mk(2'b10, 28'h3e0, 2'b00), 1'b0); tick();
        in_valid = 1'b0;
        chk("stray_c1_err", 64'(proto_err), 64'd0);
        tick();
        chk("stray_c2_err", 64'(proto_err), 64'd1);
        chk("stray_c2_req", 64'(route_req_valid), 64'd0);
        tick();
        chk("stray_c3_err", 64'(proto_err), 64'd0);
        chk("stray_out_valid", 64'(out_valid), 64'd0);
        send_pkt(3, 1, 2'b01, 28'h3f0);
        tick();
        chk("ht_relieve_once", 64'(route_relieve), 64'd0);

        // Reset while VC1 is ACTIVE with 2 flits buffered.
        out_ready = 1'b0;
        drive(1, mk(2'b01, 28'h600, 2'b01), 1'b0); tick();
        drive(1, mk(2'b10, 28'h601, 2'b01), 1'b0); tick();
        in_valid = 1'b0;
        route_grant = 4'b0010;
        tick();
        route_grant = '0;
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'hf);
        chk("mid_rst_relieve", 64'(route_relieve), 64'd0);
        chk("mid_rst_req", 64'(route_req_valid), 64'd0);
        tick();
        chk("post_rst_relieve", 64'(route_relieve), 64'd0);
        chk("post_rst_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        send_pkt(1, 3, 2'b11, 28'h700);
        tick();

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vc_input_port.md
# vc_input_port

Parametrised multi-virtual-channel router input port. Each VC has its own flit FIFO and its own route-reservation state machine, so packets on different VCs interleave flit by flit. The port sits between an upstream link and the switch allocator/crossbar. It requests a route per VC from the head flit, forwards granted flits through a round-robin output arbiter, and releases the route after the tail flit.

## Interface
- VC, 4, number of virtual channels (≥2)
- DATA_WIDTH, 32, flit width
- TYPE_WIDTH, 2, flit type field, located at data[DATA_WIDTH-1 -: TYPE_WIDTH]
- REQUEST_WIDTH, 2, route field of a head flit, located at data[REQUEST_WIDTH-1:0]
- FIFO_DEPTH, 8, flits per VC FIFO (power of 2, ≥2)
- VCW (localparam), $clog2(VC)

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- in_data  in  DATA_WIDTH  incoming flit
- in_vc  in  VCW  VC of incoming flit
- in_valid  in  1  incoming flit valid
- in_ready  out  VC  per-VC space available; equals ~full[v]
- out_data  out  DATA_WIDTH  head flit of the selected VC
- out_vc  out  VCW  selected VC
- out_valid  out  1  a granted VC has a flit
- out_ready  in  1  downstream accepts
- route_req_valid  out  VC  per-VC route request
- route_req  out  VC*REQUEST_WIDTH  per-VC route field, slice v = [v*REQUEST_WIDTH +: REQUEST_WIDTH]
- route_grant  in  VC  per-VC route reservation granted
- route_relieve  out  VC  one-cycle pulse: route of VC v released
- proto_err  out  1  one-cycle pulse: stray non-head flit dropped

## Operation
- Flit types: 2'b00 head-tail (single), 2'b01 head, 2'b10 body, 2'b11 tail. Only the low 2 bits of the type field are decoded.
- Push: when in_valid && in_ready[in_vc], in_data is written to FIFO[in_vc]. If in_vc ≥ VC, the flit is ignored and not accepted.
- Per-VC FSM states: IDLE, REQUEST, ACTIVE.
  - IDLE: if the FIFO is non-empty and its front flit is head or head-tail, go to REQUEST. If the front flit is body or tail, pop it, pulse proto_err, and stay in IDLE.
  - REQUEST: route_req_valid[v]=1 and route_req slice = front flit [REQUEST_WIDTH-1:0], held stable. On route_grant[v], go to ACTIVE. route_grant is ignored in any other state.
  - ACTIVE: VC is eligible for output when its FIFO is non-empty. When a tail or head-tail flit is popped, go to IDLE and pulse route_relieve[v] in the following cycle.
- Output arbiter: round-robin over eligible VCs, starting from pointer rr.
  - out_data, out_vc and out_valid are combinational from the FIFO heads and the FSM states.
  - On out_valid && out_ready, the selected FIFO pops and rr becomes sel+1 (mod VC).
  - With no handshake, rr and the selection hold, so out_data stays stable while out_valid=1 && !out_ready.
- A simultaneous push and pop on the same VC is legal. Occupancy is unchanged.
- in_ready depends only on full, not on a same-cycle pop.
- Counters are $clog2(FIFO_DEPTH)+1 bits. Pointers wrap modulo FIFO_DEPTH.
- proto_err and route_relieve are registered.

## Timing
- Reset, applied on a clk edge with rst=1: all FIFOs empty, all FSMs IDLE, rr=0.
  - Resulting outputs: in_ready=all 1s, out_valid=0, route_req_valid=0, route_relieve=0, proto_err=0.
  - Reset mid-packet discards all buffered flits and reservations. No relieve pulse is issued.
- Head accepted in cycle 0 reaches FIFO front in cycle 1. The VC is in REQUEST in cycle 2. With route_grant in cycle 2, it is ACTIVE in cycle 3 and out_valid=1 in cycle 3.
- Body flit pushed in cycle t to an ACTIVE VC: out_valid earliest in cycle t+1.
- Tail popped in cycle t: route_relieve[v]=1 in cycle t+1 only, FSM IDLE in t+1. The next head may enter REQUEST in t+2.
- Stray flit: dropped in the cycle it is seen at the front in IDLE. proto_err=1 in the next cycle.
- Throughput: one flit per cycle aggregate at the output. One push per cycle at the input.

## Test plan
- Single VC, 4-flit packet (head route=2'b10, body, body, tail) on VC1 with grant in the first REQUEST cycle -> route_req_valid[1] in cycle 2, route_req slice 2'b10; four flits out in cycles 3–6 in order; route_relieve[1] pulse in cycle 7.
- Fill VC0 with FIFO_DEPTH=8 flits while it is ungranted -> in_ready[0]=0 after the 8th push, with other VCs still ready. Then grant and out_ready=1 -> in_ready[0] returns to 1 the cycle after the first pop. Verify pointer wrap over 3 packets.
- VC0 and VC2 both ACTIVE with 3 flits each, out_ready=1 -> out_vc sequence 0,2,0,2,0,2.
- Drop out_ready for 3 cycles mid-packet -> out_data and out_vc stable, no pop.
- Body flit pushed to an IDLE empty VC3 -> flit dropped, proto_err pulses once, VC3 stays IDLE. A following head-tail flit is requested and forwarded, and route_relieve[3] pulses once.
- Assert rst while VC1 is ACTIVE holding 2 flits -> next cycle out_valid=0, in_ready=all 1s, no route_relieve pulse. A fresh packet then completes normally.
